// File: rtl/s_64spi_if.sv
// s_64spi_if: SPI pins plus the 64-bit word side of the s_64spi slave.
// The master modport is the SPI master / host view; the slave modport is the endpoint.
interface s_64spi_if #(
   parameter int DATA_WIDTH = 32
);
   logic                      SCLK_SLAVE;
   logic                      SS_N_SLAVE;
   logic                      MOSI_SLAVE;
   logic                      MISO_SLAVE;
   logic [2*DATA_WIDTH-1:0]   tx_data;
   logic [2*DATA_WIDTH-1:0]   rx_data;
   logic                      rx_valid;
   logic                      busy;
   logic                      err;

   modport master (
      output SCLK_SLAVE, SS_N_SLAVE, MOSI_SLAVE, tx_data,
      input  MISO_SLAVE, rx_data, rx_valid, busy, err
   );

   modport slave (
      input  SCLK_SLAVE, SS_N_SLAVE, MOSI_SLAVE, tx_data,
      output MISO_SLAVE, rx_data, rx_valid, busy, err
   );
endinterface

// File: rtl/s_64spi.sv
// s_64spi: mode-0 SPI slave moving one 64-bit word as two 32-bit frames, low word first.
// Optional gap timeout enabled by defining SPI_SLAVE_TIMEOUT_EN.
module s_64spi #(
   parameter int DATA_WIDTH     = 32,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        resetn,
   s_64spi_if.slave    bus
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 2);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_TOP  = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      FRAME0,
      GAP,
      FRAME1,
      DONE
   } state_t;

   state_t              state;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                sclk_prev;
   logic                ss_prev;
   logic [CW-1:0]       cnt;
   logic [W-1:0]        rx_sh;
   logic [W-1:0]        lo_word;
   logic [2*W-1:0]      shadow;
   logic [2*W-1:0]      rx_q;
   logic                miso_q;
   logic                rx_valid_q;
   logic                busy_q;
   logic                err_q;

   logic                sclk_s;
   logic                ss_s;
   logic                mosi_s;
   logic                sclk_rise;
   logic                sclk_fall;
   logic                ss_rise;
   logic                ss_fall;
   logic [CW-1:0]       cnt_nx;
   logic [W-1:0]        rx_nx;
   logic [W-1:0]        half;
   logic [CW-1:0]       idx;
   logic                bit_nx;

`ifdef SPI_SLAVE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]       tcnt;
`endif

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign ss_rise   = ss_s & ~ss_prev;
   assign ss_fall   = ~ss_s & ss_prev;

   // SS_N synchroniser idles high so reset release never looks like a frame start
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK_SLAVE};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SS_N_SLAVE};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI_SLAVE};
         sclk_prev <= sclk_s;
         ss_prev   <= ss_s;
      end
   end

   // Rising-edge effects are folded in first so a coincident SS_N rise sees them
   always_comb begin
      cnt_nx = cnt;
      rx_nx  = rx_sh;
      if (sclk_rise) begin
         rx_nx = {rx_sh[W-2:0], mosi_s};
         if (cnt != CNT_SAT) begin
            cnt_nx = cnt + 1'b1;
         end
      end
   end

   always_comb begin
      half   = (state == FRAME1) ? shadow[2*W-1:W] : shadow[W-1:0];
      idx    = CNT_TOP - cnt;
      bit_nx = 1'b0;
      if (cnt < CNT_FULL) begin
         bit_nx = half[idx[IW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         rx_sh      <= '0;
         lo_word    <= '0;
         shadow     <= '0;
         rx_q       <= '0;
         miso_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef SPI_SLAVE_TIMEOUT_EN
         tcnt       <= '0;
`endif
      end else begin
         rx_valid_q <= 1'b0;
         err_q      <= 1'b0;
         case (state)
            IDLE: begin
               miso_q <= 1'b0;
               busy_q <= 1'b0;
               if (ss_fall) begin
                  shadow <= bus.tx_data;
                  miso_q <= bus.tx_data[W-1];
                  busy_q <= 1'b1;
                  cnt    <= '0;
                  rx_sh  <= '0;
                  state  <= FRAME0;
               end
            end
            FRAME0, FRAME1: begin
               cnt   <= cnt_nx;
               rx_sh <= rx_nx;
               if (sclk_fall) begin
                  miso_q <= bit_nx;
               end
               if (ss_rise) begin
                  miso_q <= 1'b0;
                  if (cnt_nx == CNT_FULL) begin
                     if (state == FRAME0) begin
                        lo_word <= rx_nx;
                        state   <= GAP;
`ifdef SPI_SLAVE_TIMEOUT_EN
                        tcnt    <= '0;
`endif
                     end else begin
                        state <= DONE;
                     end
                  end else begin
                     err_q  <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            GAP: begin
               miso_q <= 1'b0;
`ifdef SPI_SLAVE_TIMEOUT_EN
               tcnt <= tcnt + 1'b1;
`endif
               if (ss_fall) begin
                  miso_q <= shadow[2*W-1];
                  cnt    <= '0;
                  rx_sh  <= '0;
                  state  <= FRAME1;
               end
`ifdef SPI_SLAVE_TIMEOUT_EN
               else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  err_q  <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
`endif
            end
            DONE: begin
               rx_q       <= {rx_sh, lo_word};
               rx_valid_q <= 1'b1;
               busy_q     <= 1'b0;
               miso_q     <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.MISO_SLAVE = miso_q;
   assign bus.rx_data    = rx_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_s_64spi.sv
// tb_s_64spi: vector table plus corner-case sequences for the s_64spi slave.
// Expected rx words go through a scoreboard queue and are matched against rx_valid captures.
module tb_s_64spi;

   logic clk;
   logic resetn;
   int   vec;
   int   miss;
   int   nvalid;
   int   nerr;
   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] last_exp;

   s_64spi_if #(.DATA_WIDTH(32)) bus ();

   s_64spi #(
      .DATA_WIDTH     (32),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.rx_valid) begin
         nvalid <= nvalid + 1;
         got_q.push_back(bus.rx_data);
      end
      if (bus.err) begin
         nerr <= nerr + 1;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [63:0] tx;
      logic [31:0] f0;
      logic [31:0] f1;
      logic [63:0] exp_rx;
      logic [31:0] exp_m0;
      logic [31:0] exp_m1;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      vec++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic sb_check(input string name);
      logic [63:0] e;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
         vec++;
         miss++;
         $display("FAIL %s got none exp %h", name, e);
      end else begin
         chk(name, got_q.pop_front(), e);
      end
   endtask

   task automatic frame(input logic [31:0] w, input int nbits,
                        input bit end_ss, output logic [31:0] mi);
      logic [31:0] sh;
      sh = w;
      mi = '0;
      bus.MOSI_SLAVE = sh[31];
      bus.SS_N_SLAVE = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         bus.MOSI_SLAVE = sh[31];
         sh = sh << 1;
         repeat (6) @(negedge clk);
         if (i < 32) mi = {mi[30:0], bus.MISO_SLAVE};
         bus.SCLK_SLAVE = 1'b1;
         repeat (6) @(negedge clk);
         bus.SCLK_SLAVE = 1'b0;
      end
      repeat (6) @(negedge clk);
      chk("busy_in_frame", 64'(bus.busy), 64'd1);
      if (end_ss) bus.SS_N_SLAVE = 1'b1;
   endtask

   task automatic wait_end(output int lat);
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (bus.rx_valid || bus.err) begin
            lat = c;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic xfer(input logic [63:0] tx, input logic [31:0] f0,
                       input logic [31:0] f1, input logic [63:0] exp_rx,
                       output logic [31:0] m0, output logic [31:0] m1,
                       output int lat);
      bus.tx_data = tx;
      exp_q.push_back(exp_rx);
      frame(f0, 32, 1'b1, m0);
      repeat (10) @(negedge clk);
      chk("busy_in_gap", 64'(bus.busy), 64'd1);
      bus.tx_data = '1;
      frame(f1, 32, 1'b1, m1);
      wait_end(lat);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [31:0] m0, m1;
      int lat, v0, e0;
      vec = 0;
      miss = 0;
      nvalid = 0;
      nerr = 0;
      resetn = 1'b0;
      bus.SS_N_SLAVE = 1'b1;
      bus.SCLK_SLAVE = 1'b0;
      bus.MOSI_SLAVE = 1'b0;
      bus.tx_data = '0;

      tbl[0] = '{64'hA5A5_0000_1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D,
                 64'h0BAD_F00D_DEAD_BEEF, 32'h1234_5678, 32'hA5A5_0000};
      tbl[1] = '{64'h0, 32'hFFFF_FFFF, 32'h0,
                 64'h0000_0000_FFFF_FFFF, 32'h0, 32'h0};
      tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h8000_0001,
                 64'h8000_0001_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[3] = '{64'h8000_0001_0000_0001, 32'hAAAA_5555, 32'h5555_AAAA,
                 64'h5555_AAAA_AAAA_5555, 32'h0000_0001, 32'h8000_0001};
      tbl[4] = '{64'h0123_4567_89AB_CDEF, 32'h1357_9BDF, 32'h2468_ACE0,
                 64'h2468_ACE0_1357_9BDF, 32'h89AB_CDEF, 32'h0123_4567};

      repeat (5) @(negedge clk);
      chk("rst_rx_data", bus.rx_data, 64'h0);
      chk("rst_rx_valid", 64'(bus.rx_valid), 64'h0);
      chk("rst_busy", 64'(bus.busy), 64'h0);
      chk("rst_err", 64'(bus.err), 64'h0);
      chk("rst_miso", 64'(bus.MISO_SLAVE), 64'h0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      for (int k = 0; k < 5; k++) begin
         v0 = nvalid;
         e0 = nerr;
         xfer(tbl[k].tx, tbl[k].f0, tbl[k].f1, tbl[k].exp_rx, m0, m1, lat);
         chk("miso_frame0", 64'(m0), 64'(tbl[k].exp_m0));
         chk("miso_frame1", 64'(m1), 64'(tbl[k].exp_m1));
         chk("rx_valid_latency", 64'(lat), 64'd4);
         chk("rx_valid_count", 64'(nvalid - v0), 64'd1);
         chk("err_count", 64'(nerr - e0), 64'd0);
         chk("busy_after", 64'(bus.busy), 64'd0);
         sb_check("rx_data");
         last_exp = tbl[k].exp_rx;
      end

      // short frame 0
      e0 = nerr;
      bus.tx_data = 64'h1111_2222_3333_4444;
      frame(32'hCAFE_BABE, 31, 1'b1, m0);
      repeat (10) @(negedge clk);
      chk("short_err", 64'(nerr - e0), 64'd1);
      chk("short_busy", 64'(bus.busy), 64'd0);
      chk("short_rx_hold", bus.rx_data, last_exp);
      xfer(64'h1111_2222_3333_4444, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
           64'hF0F0_F0F0_0F0F_0F0F, m0, m1, lat);
      chk("after_short_m0", 64'(m0), 64'h3333_4444);
      sb_check("after_short_rx");
      last_exp = 64'hF0F0_F0F0_0F0F_0F0F;

      // overrun on frame 1
      v0 = nvalid;
      e0 = nerr;
      bus.tx_data = 64'h0;
      frame(32'h1234_0000, 32, 1'b1, m0);
      repeat (10) @(negedge clk);
      frame(32'h0000_4321, 33, 1'b1, m1);
      repeat (10) @(negedge clk);
      chk("overrun_err", 64'(nerr - e0), 64'd1);
      chk("overrun_valid", 64'(nvalid - v0), 64'd0);
      chk("overrun_busy", 64'(bus.busy), 64'd0);
      chk("overrun_rx_hold", bus.rx_data, last_exp);

      // reset in the middle of frame 1
      e0 = nerr;
      bus.tx_data = 64'h7777_8888_9999_AAAA;
      frame(32'h5A5A_5A5A, 32, 1'b1, m0);
      repeat (10) @(negedge clk);
      frame(32'hA5A5_A5A5, 10, 1'b0, m1);
      resetn = 1'b0;
      #1;
      chk("midrst_rx_data", bus.rx_data, 64'h0);
      chk("midrst_busy", 64'(bus.busy), 64'h0);
      chk("midrst_miso", 64'(bus.MISO_SLAVE), 64'h0);
      chk("midrst_rx_valid", 64'(bus.rx_valid), 64'h0);
      bus.SS_N_SLAVE = 1'b1;
      repeat (5) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_no_err", 64'(nerr - e0), 64'd0);
      xfer(64'h0, 32'h1, 32'h0, 64'h1, m0, m1, lat);
      sb_check("after_reset_rx");

`ifdef SPI_SLAVE_TIMEOUT_EN
      e0 = nerr;
      bus.tx_data = 64'hBBBB_CCCC_DDDD_EEEE;
      frame(32'h0000_FFFF, 32, 1'b1, m0);
      lat = 0;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk);
         #1;
         if (bus.err) begin
            lat = c;
            break;
         end
      end
      chk("timeout_cycle", 64'(lat), 64'd103);
      @(negedge clk);
      chk("timeout_busy", 64'(bus.busy), 64'd0);
      repeat (47) @(negedge clk);
      chk("timeout_err", 64'(nerr - e0), 64'd1);
      xfer(64'h0102_0304_0506_0708, 32'hFFFF_0000, 32'h00FF_FF00,
           64'h00FF_FF00_FFFF_0000, m0, m1, lat);
      chk("late_frame0_miso", 64'(m0), 64'h0506_0708);
      sb_check("late_rx");
`else
      e0 = nerr;
      bus.tx_data = 64'hBBBB_CCCC_DDDD_EEEE;
      exp_q.push_back(64'h0000_FFFF_0000_FFFF);
      frame(32'h0000_FFFF, 32, 1'b1, m0);
      repeat (150) @(negedge clk);
      chk("long_gap_busy", 64'(bus.busy), 64'd1);
      chk("long_gap_err", 64'(nerr - e0), 64'd0);
      frame(32'h0000_FFFF, 32, 1'b1, m1);
      wait_end(lat);
      repeat (4) @(negedge clk);
      chk("long_gap_m1", 64'(m1), 64'hBBBB_CCCC);
      sb_check("long_gap_rx");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/s_64spi.md
Name: s_64spi

Overview:
- SPI slave endpoint that pairs with the 64-bit master wrapper.
- Receives one 64-bit transfer as two consecutive 32-bit SPI frames: low word first, then high word.
- Returns a 64-bit response word on MISO in the same order.
- Shifts serial data directly in the system clock domain by oversampling synchronised SPI pins; no vendor SPI IP is used.

Parameters:
- DATA_WIDTH, 32, bits per SPI frame; a transfer is always 2 frames.
- SYNC_STAGES, 2, flip-flop depth of the SCLK/SS_N/MOSI synchronisers (minimum 2).
- TIMEOUT_CYCLES, 4096, maximum clk cycles between end of frame 0 and start of frame 1. Used only with SPI_SLAVE_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; must be at least 8x SCLK frequency.
- resetn  input  1  reset, asynchronous, active-low; asserted 0 clears all state.
- SCLK_SLAVE  input  1  SPI clock from master; mode 0 (idle low).
- SS_N_SLAVE  input  1  active-low frame select.
- MOSI_SLAVE  input  1  serial data in, MSB first.
- MISO_SLAVE  output  1  serial data out, MSB first.
- tx_data  input  64  response word; [31:0] goes in frame 0, [63:32] in frame 1.
- rx_data  output  64  last completed received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high while a 64-bit transfer is in progress.
- err  output  1  one-cycle pulse on an aborted transfer.

Behaviour:
- Reset values: MISO_SLAVE=0, rx_data=0, rx_valid=0, busy=0, err=0, FSM=IDLE, bit counter=0, shift registers=0.
- Synchronisation: SCLK, SS_N and MOSI each pass through SYNC_STAGES flops. Edges are detected from the last two synchronised samples. MOSI is sampled from the same synchronised stage as the SCLK rising edge.
- Mode 0 timing: capture MOSI on SCLK rising edge; advance MISO on SCLK falling edge.
- FSM states: IDLE, FRAME0, GAP, FRAME1, DONE.
- IDLE:
  - On SS_N fall: latch tx_data into a 64-bit shadow register.
  - Drive MISO = shadow[31], set busy=1, clear bit counter, go to FRAME0.
- FRAME0 / FRAME1, each SCLK rising edge:
  - Shift MOSI into the rx shift register LSB side.
  - Increment the bit counter (6-bit, saturating at 33).
- FRAME0 / FRAME1, each SCLK falling edge:
  - Output the next lower bit of the current shadow half.
  - After bit 0, hold MISO at 0.
- Frame end on SS_N rise:
  - Bit counter == 32: frame is good. FRAME0 stores the low word and goes to GAP. FRAME1 goes to DONE.
  - Bit counter != 32 (short frame or overrun): pulse err, set busy=0, go to IDLE, leave rx_data unchanged.
- GAP:
  - MISO=0 while SS_N is high.
  - On SS_N fall: drive MISO = shadow[63], clear counter, go to FRAME1.
- DONE (one cycle):
  - rx_data = {frame1 word, frame0 word}.
  - rx_valid=1, busy=0, then go to IDLE.
  - rx_valid asserts SYNC_STAGES+2 clk cycles after the SS_N pin rising edge.
- MISO is 0 whenever SS_N is high (synchronised view).
- tx_data changes after the frame-0 latch do not affect the current transfer.
- SCLK edges while SS_N is high are ignored.
- Simultaneous SS_N rise and SCLK edge in the same synchronised cycle: the SCLK edge is processed first, then the frame end.
- resetn asserted mid-transfer: immediate return to reset values, no err pulse. The next SS_N fall starts a fresh frame 0.

Optional Feature:
- Macro: SPI_SLAVE_TIMEOUT_EN.
- When defined:
  - A counter runs in GAP.
  - If TIMEOUT_CYCLES elapse without an SS_N fall, pulse err, set busy=0 and return to IDLE.
  - A later frame is then treated as a new frame 0.
- When undefined: GAP waits indefinitely, the counter is not instantiated, and TIMEOUT_CYCLES is unused.

Test Plan:
- Normal transfer:
  - Stimulus: tx_data=64'hA5A5_0000_1234_5678. Master sends frame 0 = 32'hDEAD_BEEF, then frame 1 = 32'h0BAD_F00D.
  - Required: rx_data=64'h0BAD_F00D_DEAD_BEEF with a single rx_valid pulse. MISO streams 32'h1234_5678 then 32'hA5A5_0000. busy is high throughout, err is never asserted.
- Short frame:
  - Stimulus: frame 0 contains only 31 SCLK cycles.
  - Required: err pulses once, busy=0, rx_data keeps its prior value. A following full 2-frame transfer then completes correctly.
- Overrun:
  - Stimulus: frame 1 contains 33 SCLK cycles.
  - Required: err pulse, no rx_valid.
- tx_data stability:
  - Stimulus: change tx_data to all ones during GAP.
  - Required: frame 1 still shifts the originally latched high word.
- Reset mid-transfer:
  - Stimulus: pull resetn low during FRAME1 after 10 bits.
  - Required: all outputs return to reset values immediately. The next transfer of 64'h1 completes with rx_data=64'h1.
- Timeout (SPI_SLAVE_TIMEOUT_EN defined, TIMEOUT_CYCLES=100):
  - Stimulus: hold the gap at 150 cycles.
  - Required: err at cycle 100 of GAP, busy drops. The late frame is treated as a new frame 0.
